// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall handling
// and write-back bypass of the register-file read data.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_ext,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic [3:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc,
  output logic              load_use_stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              flushPending;
  logic              effFlush;
  logic              rs1Bypass;
  logic              rs2Bypass;
  logic [DATA_W-1:0] rs1Fwd;
  logic [DATA_W-1:0] rs2Fwd;

  assign load_use_stall = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                          ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign pc_write    = ~(load_use_stall | stall_ext);
  assign if_id_write = ~(load_use_stall | stall_ext);
  assign effFlush    = flush | flushPending;

  // The register file is read in ID while WB writes in the same cycle, so the
  // freshest value must come from WB; x0 is hardwired and never bypassed.
  assign rs1Bypass = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs1);
  assign rs2Bypass = wb_reg_write & (wb_rd != '0) & (wb_rd == id_rs2);
  assign rs1Fwd    = rs1Bypass ? wb_data : id_rs1_data;
  assign rs2Fwd    = rs2Bypass ? wb_data : id_rs2_data;

  // A flush that arrives while frozen must survive until the stall lifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushPending <= 1'b0;
    end else if (stall_ext) begin
      flushPending <= flushPending | flush;
    end else begin
      flushPending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_pc         <= '0;
      bubble_count  <= '0;
    end else if (stall_ext) begin
      ex_valid <= ex_valid;
    end else if (effFlush || load_use_stall) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_alu_op     <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_pc         <= '0;
      // Only genuine load-use bubbles are counted; a flush takes precedence.
      if (!effFlush && bubble_count != {CNT_W{1'b1}}) begin
        bubble_count <= bubble_count + CNT_W'(1);
      end
    end else begin
      ex_valid      <= id_valid;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_alu_op     <= id_alu_op;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_rs1_data   <= rs1Fwd;
      ex_rs2_data   <= rs2Fwd;
      ex_imm        <= id_imm;
      ex_pc         <= id_pc;
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed self-checking bench for id_ex_hazard_reg; a narrow bubble counter
// keeps the saturation run short.
module tb_id_ex_hazard_reg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int TB_CNT_W = 10;
  localparam logic [31:0] CNT_MAX = (32'd1 << TB_CNT_W) - 32'd1;

  logic clk = 1'b0;
  logic rst_n;
  logic stall_ext, flush, id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [3:0] id_alu_op;
  logic [DATA_W-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic wb_reg_write;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0] ex_alu_op;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [DATA_W-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic load_use_stall, pc_write, if_id_write;
  logic [TB_CNT_W-1:0] bubble_count;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall_ext(stall_ext), .flush(flush),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_pc(ex_pc),
    .load_use_stall(load_use_stall), .pc_write(pc_write),
    .if_id_write(if_id_write), .bubble_count(bubble_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Loads, and only loads, use memToReg and the immediate operand.
  task automatic applyStimulus(input logic valid, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic regWrite, input logic memRead,
                               input logic [3:0] aluOp, input logic [31:0] rs1Data,
                               input logic [31:0] rs2Data, input logic [31:0] imm,
                               input logic [31:0] pc);
    id_valid      = valid;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_reg_write  = regWrite;
    id_mem_read   = memRead;
    id_mem_write  = 1'b0;
    id_mem_to_reg = memRead;
    id_alu_src    = memRead;
    id_alu_op     = aluOp;
    id_rs1_data   = rs1Data;
    id_rs2_data   = rs2Data;
    id_imm        = imm;
    id_pc         = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    stall_ext = 1'b0;
    flush = 1'b0;
    wb_reg_write = 1'b0;
    wb_rd = '0;
    wb_data = '0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("resetValid", {31'b0, ex_valid}, 32'd0);
    checkOutput("resetCount", 32'(bubble_count), 32'd0);
    checkOutput("resetPcWrite", {31'b0, pc_write}, 32'd1);
    rst_n = 1'b1;

    // Plain ALU instruction passes through with one cycle of latency
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 4'h2, 32'hA, 32'hB, 32'h10, 32'h100);
    tick();
    checkOutput("passValid", {31'b0, ex_valid}, 32'd1);
    checkOutput("passRd", 32'(ex_rd), 32'd3);
    checkOutput("passAluOp", 32'(ex_alu_op), 32'h2);
    checkOutput("passRs1Data", ex_rs1_data, 32'hA);
    checkOutput("passImm", ex_imm, 32'h10);
    checkOutput("passPc", ex_pc, 32'h100);

    // Load x5 followed by a consumer of x5 on rs2
    applyStimulus(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 32'h4, 32'h104);
    tick();
    applyStimulus(1'b1, 5'd6, 5'd5, 5'd8, 1'b1, 1'b0, 4'h1, 32'h6, 32'h5, 32'h0, 32'h108);
    #1;
    checkOutput("luStall", {31'b0, load_use_stall}, 32'd1);
    checkOutput("luPcWrite", {31'b0, pc_write}, 32'd0);
    checkOutput("luIfIdWrite", {31'b0, if_id_write}, 32'd0);
    tick();
    checkOutput("luBubbleValid", {31'b0, ex_valid}, 32'd0);
    checkOutput("luBubbleRd", 32'(ex_rd), 32'd0);
    checkOutput("luBubbleMemRead", {31'b0, ex_mem_read}, 32'd0);
    checkOutput("luCount", 32'(bubble_count), 32'd1);
    checkOutput("luStallCleared", {31'b0, load_use_stall}, 32'd0);
    tick();
    checkOutput("luReissueValid", {31'b0, ex_valid}, 32'd1);
    checkOutput("luReissueRs2", 32'(ex_rs2), 32'd5);
    checkOutput("luReissueRd", 32'(ex_rd), 32'd8);

    // Load into x0 never creates a hazard
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 32'h10C);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h110);
    #1;
    checkOutput("x0MemRead", {31'b0, ex_mem_read}, 32'd1);
    checkOutput("x0NoStall", {31'b0, load_use_stall}, 32'd0);

    // WB bypass on rs1, then on rs2, then never for x0
    wb_reg_write = 1'b1;
    wb_rd = 5'd7;
    wb_data = 32'hDEADBEEF;
    applyStimulus(1'b1, 5'd7, 5'd3, 5'd9, 1'b1, 1'b0, 4'h0, 32'h11, 32'h22, 32'h0, 32'h114);
    tick();
    checkOutput("bypassRs1", ex_rs1_data, 32'hDEADBEEF);
    checkOutput("bypassRs2Untouched", ex_rs2_data, 32'h22);
    wb_rd = 5'd9;
    applyStimulus(1'b1, 5'd1, 5'd9, 5'd10, 1'b1, 1'b0, 4'h0, 32'h33, 32'h44, 32'h0, 32'h118);
    tick();
    checkOutput("bypassRs2", ex_rs2_data, 32'hDEADBEEF);
    checkOutput("bypassRs1Untouched", ex_rs1_data, 32'h33);
    wb_rd = 5'd0;
    applyStimulus(1'b1, 5'd0, 5'd2, 5'd10, 1'b1, 1'b0, 4'h0, 32'h11, 32'h55, 32'h0, 32'h11C);
    tick();
    checkOutput("bypassX0", ex_rs1_data, 32'h11);
    wb_reg_write = 1'b0;

    // Stall with a flush arriving in the first stalled cycle
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 4'h3, 32'h1, 32'h2, 32'h0, 32'h200);
    tick();
    applyStimulus(1'b1, 5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 4'h4, 32'h3, 32'h4, 32'h0, 32'h300);
    stall_ext = 1'b1;
    flush = 1'b1;
    #1;
    checkOutput("stallPcWrite", {31'b0, pc_write}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      flush = 1'b0;
      checkOutput($sformatf("stallHoldPc%0d", i), ex_pc, 32'h200);
      checkOutput($sformatf("stallHoldRd%0d", i), 32'(ex_rd), 32'd10);
    end
    stall_ext = 1'b0;
    tick();
    checkOutput("pendingBubbleValid", {31'b0, ex_valid}, 32'd0);
    checkOutput("pendingBubblePc", ex_pc, 32'h0);
    tick();
    checkOutput("pendingClearedValid", {31'b0, ex_valid}, 32'd1);
    checkOutput("pendingClearedRd", 32'(ex_rd), 32'd11);
    checkOutput("flushNoCount", 32'(bubble_count), 32'd1);

    // Flush and load-use together: flush wins, no count, PC still frozen
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 32'h8, 32'h304);
    tick();
    applyStimulus(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h308);
    flush = 1'b1;
    #1;
    checkOutput("flushLuStall", {31'b0, load_use_stall}, 32'd1);
    checkOutput("flushLuPcWrite", {31'b0, pc_write}, 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("flushLuBubble", {31'b0, ex_valid}, 32'd0);
    checkOutput("flushLuCount", 32'(bubble_count), 32'd1);
    tick();
    checkOutput("flushLuReload", 32'(ex_rd), 32'd13);

    // Reset mid-cycle while a flush is pending under stall
    stall_ext = 1'b1;
    flush = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    stall_ext = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("asyncResetValid", {31'b0, ex_valid}, 32'd0);
    checkOutput("asyncResetRd", 32'(ex_rd), 32'd0);
    checkOutput("asyncResetPc", ex_pc, 32'h0);
    checkOutput("asyncResetCount", 32'(bubble_count), 32'd0);
    checkOutput("asyncResetPcWrite", {31'b0, pc_write}, 32'd1);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b1, 5'd1, 5'd2, 5'd14, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h400);
    tick();
    checkOutput("resetClearsPending", {31'b0, ex_valid}, 32'd1);

    // lw x5,0(x5) held in ID produces a bubble every other cycle
    applyStimulus(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 4'h0, 32'h0, 32'h0, 32'h0, 32'h500);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("countMid", 32'(bubble_count), 32'd10);
    for (int i = 0; i < 2200; i++) tick();
    checkOutput("countSaturated", 32'(bubble_count), CNT_MAX);
    tick();
    tick();
    checkOutput("countStaysSaturated", 32'(bubble_count), CNT_MAX);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
